// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Contents:
//   UART_DATA_W   - serial byte width
//   UART_TAG_BASE - default upper nibble source for the channel tag byte
//   arb_state_e   - arbiter FSM state encodings (tag states only reached with UART_ARB_TAG_EN)
//   tag_byte()    - builds the tag byte {base[7:4], channel id}
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam logic [7:0] UART_TAG_BASE = 8'hA0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TAG_START = 3'd1,
        ST_TAG_WAIT  = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT      = 3'd4
    } arb_state_e;

    function automatic logic [7:0] tag_byte(input logic [7:0] base, input logic [3:0] id);
        return {base[7:4], id};
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_valid [NUM_REQ] - requests
//   rr_ptr    [ID_W]    - highest-priority channel this round
//   grant_oh  [NUM_REQ] - one-hot winner (all-zero when no request)
//   grant_id  [ID_W]    - winner index
//   any       [1]       - at least one request present
module uart_rr_pick import uart_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [ID_W-1:0]    grant_id,
    output logic               any
);

    logic [ID_W-1:0] idx_s;
    logic            found_s;

    // Scan channels starting at rr_ptr, wrapping, and take the first valid one.
    always_comb begin
        grant_oh = '0;
        grant_id = '0;
        idx_s    = '0;
        found_s  = 1'b0;
        any      = |req_valid;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found_s && req_valid[idx_s]) begin
                found_s         = 1'b1;
                grant_id        = idx_s;
                grant_oh[idx_s] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx serializer between NUM_REQ byte
// producers. One byte is accepted per grant; the byte is handed to uart_tx with
// a one-cycle tx_start pulse and held on tx_data until tx_done.
// Optional feature macro: UART_ARB_TAG_EN - each grant first sends a tag byte
// {TAG_BASE[7:4], channel id}, then the payload byte.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   req_valid [NUM_REQ]   - per-channel byte available
//   req_data  [8*NUM_REQ] - channel i byte at [8*i+7:8*i]
//   req_ready [NUM_REQ]   - one-hot accept, only in IDLE
//   tx_start, tx_data     - to uart_tx
//   tx_done               - completion pulse from uart_tx
//   busy                  - FSM not idle
//   gnt_id    [ID_W]      - channel currently/last granted
module uart_tx_arbiter import uart_pkg::*; #(
    parameter int         NUM_REQ  = 4,
    parameter int         ID_W     = 2,
    parameter logic [7:0] TAG_BASE = UART_TAG_BASE
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_start,
    output logic [UART_DATA_W-1:0]         tx_data,
    input  logic                           tx_done,
    output logic                           busy,
    output logic [ID_W-1:0]                gnt_id
);

    arb_state_e             state_r, state_nxt_s;
    logic [ID_W-1:0]        rr_ptr_r;
    logic [UART_DATA_W-1:0] data_buf_r;
    logic                   tx_start_r;
    logic [UART_DATA_W-1:0] tx_data_r;
    logic                   busy_r;
    logic [ID_W-1:0]        gnt_id_r;

    logic [NUM_REQ-1:0]     grant_oh_s;
    logic [ID_W-1:0]        win_id_s;
    logic                   any_s;
    logic [UART_DATA_W-1:0] win_data_s;
    logic [UART_DATA_W-1:0] first_byte_s;
    logic [ID_W-1:0]        rr_next_s;
    logic                   accept_s;
    logic                   load_payload_s;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_r),
        .grant_oh  (grant_oh_s),
        .grant_id  (win_id_s),
        .any       (any_s)
    );

    assign win_data_s = req_data[int'(win_id_s)*UART_DATA_W +: UART_DATA_W];
    assign rr_next_s  = (win_id_s == ID_W'(NUM_REQ - 1)) ? '0 : win_id_s + ID_W'(1);

`ifdef UART_ARB_TAG_EN
    assign first_byte_s = tag_byte(TAG_BASE, 4'(win_id_s));
`else
    logic unused_tag_s;
    assign unused_tag_s = ^TAG_BASE;
    assign first_byte_s = win_data_s;
`endif

    // Next-state logic; accept only happens from IDLE with a pending request.
    always_comb begin
        state_nxt_s    = state_r;
        accept_s       = 1'b0;
        load_payload_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    accept_s = 1'b1;
`ifdef UART_ARB_TAG_EN
                    state_nxt_s = ST_TAG_START;
`else
                    state_nxt_s = ST_START;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG_START: state_nxt_s = ST_TAG_WAIT;
            ST_TAG_WAIT: begin
                if (tx_done) begin
                    state_nxt_s    = ST_START;
                    load_payload_s = 1'b1;
                end else begin
                    state_nxt_s = ST_TAG_WAIT;
                end
            end
`endif
            ST_START: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (tx_done) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, pointer, byte buffer and registered uart_tx outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= '0;
            data_buf_r <= '0;
            tx_start_r <= 1'b0;
            tx_data_r  <= '0;
            busy_r     <= 1'b0;
            gnt_id_r   <= '0;
        end else begin
            state_r    <= state_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            // Start states last exactly one cycle, so entering one is the pulse.
            tx_start_r <= (state_nxt_s == ST_START) || (state_nxt_s == ST_TAG_START);
            if (accept_s) begin
                data_buf_r <= win_data_s;
                gnt_id_r   <= win_id_s;
                rr_ptr_r   <= rr_next_s;
                tx_data_r  <= first_byte_s;
            end else if (load_payload_s) begin
                tx_data_r <= data_buf_r;
            end
        end
    end

    assign req_ready = ((state_r == ST_IDLE) && !reset) ? grant_oh_s : '0;
    assign tx_start  = tx_start_r;
    assign tx_data   = tx_data_r;
    assign busy      = busy_r;
    assign gnt_id    = gnt_id_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int DONE_LAT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = 4'b0000;
    logic [31:0] req_data = 32'h13121110;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        model_done = 1'b0;
    logic        inj_done = 1'b0;
    logic        busy;
    logic [1:0]  gnt_id;

    int checks = 0;
    int failures = 0;

    logic [11:0] exp_q[$];     // {id, byte}
    logic [7:0]  last_data = 8'h00;
    logic        prev_start = 1'b0;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] exp_ready;
        logic [1:0] exp_id;
    } vec_t;

    vec_t vecs[14];

    assign tx_done = model_done | inj_done;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .ID_W(2), .TAG_BASE(8'hA0)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .busy      (busy),
        .gnt_id    (gnt_id)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_grant(input logic [1:0] id, input logic [7:0] payload);
`ifdef UART_ARB_TAG_EN
        exp_q.push_back({2'b00, id, 8'hA0 | {6'b000000, id}});
`endif
        exp_q.push_back({2'b00, id, payload});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Behavioural uart_tx: completion pulse DONE_LAT cycles after each start.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && reset === 1'b0) begin
                repeat (DONE_LAT) @(negedge clk);
                model_done = 1'b1;
                @(negedge clk);
                model_done = 1'b0;
            end
        end
    end

    // Output monitor: scoreboard pop on each start, hold checks while busy.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                check("start_single_cycle", 32'(prev_start), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_start", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data_at_start", 32'(tx_data), 32'(e[7:0]));
                    check("gnt_id_at_start", 32'(gnt_id), 32'(e[9:8]));
                end
                last_data = tx_data;
            end else if (busy === 1'b1 && reset === 1'b0) begin
                check("tx_data_stable", 32'(tx_data), 32'(last_data));
            end
            prev_start = (tx_start === 1'b1);
        end
    end

    initial begin
        vecs[0]  = '{4'b1111, 4'b0001, 2'd0};
        vecs[1]  = '{4'b1111, 4'b0010, 2'd1};
        vecs[2]  = '{4'b1111, 4'b0100, 2'd2};
        vecs[3]  = '{4'b1111, 4'b1000, 2'd3};
        vecs[4]  = '{4'b1111, 4'b0001, 2'd0};
        vecs[5]  = '{4'b0010, 4'b0010, 2'd1};
        vecs[6]  = '{4'b0011, 4'b0001, 2'd0};
        vecs[7]  = '{4'b0011, 4'b0010, 2'd1};
        vecs[8]  = '{4'b1000, 4'b1000, 2'd3};
        vecs[9]  = '{4'b1001, 4'b0001, 2'd0};
        vecs[10] = '{4'b1001, 4'b1000, 2'd3};
        vecs[11] = '{4'b0110, 4'b0010, 2'd1};
        vecs[12] = '{4'b0110, 4'b0100, 2'd2};
        vecs[13] = '{4'b0101, 4'b0001, 2'd0};

        // Reset: no ready even with requests pending.
        req_valid = 4'b1111;
        repeat (3) @(negedge clk);
        check("ready_in_reset", 32'(req_ready), 32'd0);
        req_valid = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_tx_start", 32'(tx_start), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_ready", 32'(req_ready), 32'd0);
            check("idle_gnt_id", 32'(gnt_id), 32'd0);
        end

        // Single byte from channel 0; valid dropped right after accept.
        req_data[7:0] = 8'h55;
        req_valid = 4'b0001;
        #1;
        check("ch0_ready", 32'(req_ready), 32'b0001);
        push_grant(2'd0, 8'h55);
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        check("ch0_ready_after", 32'(req_ready), 32'd0);
        check("ch0_start", 32'(tx_start), 32'd1);
        check("ch0_busy", 32'(busy), 32'd1);
        @(negedge clk);
        wait_idle();
        check("ch0_data_held", 32'(tx_data), 32'h55);
        check("ch0_gnt_held", 32'(gnt_id), 32'd0);
        req_data = 32'h13121110;

        // tx_done while idle is ignored.
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        @(negedge clk);
        check("done_in_idle_busy", 32'(busy), 32'd0);
        check("done_in_idle_start", 32'(tx_start), 32'd0);

        // tx_done during the start cycle is ignored; then reset mid-byte.
        req_valid = 4'b0100;
        #1;
        check("ch2_ready", 32'(req_ready), 32'b0100);
        push_grant(2'd2, 8'h12);
        @(negedge clk);
        req_valid = 4'b0000;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        check("done_in_start_busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_gnt_id", 32'(gnt_id), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        reset = 1'b0;
        repeat (DONE_LAT + 6) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Table-driven round-robin sequence starting from rr_ptr = 0.
        for (int i = 0; i < 14; i++) begin
            wait_idle();
            req_valid = vecs[i].valid;
            #1;
            check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            push_grant(vecs[i].exp_id, 8'h10 + {6'b000000, vecs[i].exp_id});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_ready_low", i), 32'(req_ready), 32'd0);
            @(negedge clk);
            wait_idle();
            check($sformatf("vec%0d_gnt_id", i), 32'(gnt_id), 32'(vecs[i].exp_id));
        end
        req_valid = 4'b0000;
        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
